i2c_reg_ctrl: RTL and testbench

I2C_REG_CTRL -- requirements
Module: i2c_reg_ctrl

---
 rtl/i2c_reg_ctrl.sv | 102 ++++++++++
 tb/tb_i2c_reg_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_ctrl.sv
// Register-file front end for an I2C slave: the first byte after START sets the pointer,
// later bytes write registers with auto-increment, and reads stream from the pointer.
module i2c_reg_ctrl #(
  parameter int             NUM_REGS = 16,
  parameter logic [7:0]     ID_VALUE = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    xfer_start,
  input  logic                    xfer_stop,
  input  logic [7:0]              wr_byte,
  input  logic                    wr_valid,
  output logic [7:0]              rd_byte,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  input  logic                    host_we,
  input  logic [3:0]              host_addr,
  input  logic [7:0]              host_wdata,
  output logic                    host_gnt,
  output logic [NUM_REGS*8-1:0]   regs_q,
  output logic                    wr_done
);

  typedef enum logic [1:0] {IDLE, PTR, WRITE, READ} state_t;

  state_t                      state, state_nxt;
  logic [3:0]                  ptr, ptr_nxt;
  logic [NUM_REGS-2:0][7:0]    regs;
  logic                        wr_flag;
  logic                        ptr_load, i2c_wr, rd_fire, stop_act;
  logic                        reg_we;
  logic [3:0]                  wr_addr;
  logic [7:0]                  wr_data;

  // START pre-empts everything else in its cycle, including a coincident byte.
  assign ptr_load = !xfer_start && (state == PTR) && wr_valid;
  assign i2c_wr   = !xfer_start && (state == WRITE) && wr_valid;
  assign rd_fire  = !xfer_start && (state != IDLE) && rd_valid && rd_ready && !ptr_load && !i2c_wr;
  assign stop_act = !xfer_start && xfer_stop && (state != IDLE);

  assign host_gnt = host_we && !i2c_wr && !rst;
  assign reg_we   = i2c_wr || host_gnt;
  assign wr_addr  = i2c_wr ? ptr : host_addr;
  assign wr_data  = i2c_wr ? wr_byte : host_wdata;

  assign regs_q   = {ID_VALUE, regs};

  always_comb begin
    ptr_nxt = ptr;
    if (ptr_load)
      ptr_nxt = wr_byte[3:0];
    else if (i2c_wr || rd_fire)
      ptr_nxt = ptr + 4'd1;
  end

  // A byte coincident with STOP is handled first, so STOP only overrides the state.
  always_comb begin
    state_nxt = state;
    if (xfer_start)
      state_nxt = PTR;
    else if (stop_act)
      state_nxt = IDLE;
    else if (ptr_load)
      state_nxt = WRITE;
    else if (rd_fire)
      state_nxt = READ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= 4'd0;
      rd_byte  <= 8'h00;
      rd_valid <= 1'b0;
      wr_done  <= 1'b0;
      wr_flag  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      rd_byte  <= regs_q[{ptr, 3'b000} +: 8];
      // rd_byte lags ptr by a cycle, so it is stale right after ptr moves.
      rd_valid <= (state_nxt != IDLE) && (ptr_nxt == ptr);
      wr_done  <= stop_act && (wr_flag || i2c_wr);
      if (xfer_start || stop_act)
        wr_flag <= 1'b0;
      else if (i2c_wr)
        wr_flag <= 1'b1;
    end
  end

  // Register 15 is the constant ID byte; writes addressed to it fall through the loop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else if (reg_we) begin
      for (int k = 0; k < NUM_REGS-1; k++)
        if (wr_addr == k[3:0])
          regs[k] <= wr_data;
    end
  end

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Directed bench for i2c_reg_ctrl: a per-cycle vector table plus hand sequences
// for the read handshake and mid-transaction reset.
module tb_i2c_reg_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         xfer_start, xfer_stop, wr_valid, rd_ready, host_we;
  logic [7:0]   wr_byte, host_wdata;
  logic [3:0]   host_addr;
  logic [7:0]   rd_byte;
  logic         rd_valid, host_gnt, wr_done;
  logic [127:0] regs_q;

  localparam logic [1:0] S_IDLE = 2'd0, S_PTR = 2'd1, S_WR = 2'd2, S_RD = 2'd3;
  localparam logic [127:0] RST_IMG = {8'hA5, 120'h0};

  i2c_reg_ctrl #(.NUM_REGS(16), .ID_VALUE(8'hA5)) dut (
    .clk(clk), .rst(rst), .xfer_start(xfer_start), .xfer_stop(xfer_stop),
    .wr_byte(wr_byte), .wr_valid(wr_valid), .rd_byte(rd_byte), .rd_valid(rd_valid),
    .rd_ready(rd_ready), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .regs_q(regs_q), .wr_done(wr_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start, stop, wv;
    logic [7:0] wb;
    logic       hwe;
    logic [3:0] ha;
    logic [7:0] hwd;
    logic       gnt, done;
    logic [1:0] st;
    logic [3:0] ptr;
    logic [3:0] ci;
    logic [7:0] cv;
  } vec_t;

  vec_t tbl [27];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] reg_at(input logic [3:0] i);
    return regs_q[{i, 3'b000} +: 8];
  endfunction

  task automatic clear_in();
    xfer_start = 0; xfer_stop = 0; wr_valid = 0; wr_byte = 8'h00; rd_ready = 0;
    host_we = 0; host_addr = 4'h0; host_wdata = 8'h00;
  endtask

  task automatic drive(input logic s, input logic p, input logic v, input logic [7:0] b);
    @(negedge clk);
    xfer_start = s; xfer_stop = p; wr_valid = v; wr_byte = b;
    @(posedge clk); #1;
    clear_in();
  endtask

  task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    host_we = 1; host_addr = a; host_wdata = d;
    @(posedge clk); #1;
    clear_in();
  endtask

  task automatic wait_rd_valid(input string nm);
    bit seen = 0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge clk);
      seen = rd_valid;
    end
    chk(nm, seen, 1'b1);
  endtask

  initial begin
    clear_in();
    // Reset state, with a pending host write that must not be granted
    rst = 1; host_we = 1; host_addr = 4'd3; host_wdata = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", host_gnt, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_wr_done", wr_done, 1'b0);
    chk("rst_regs", regs_q, RST_IMG);
    chk("rst_state", 2'(dut.state), S_IDLE);
    chk("rst_ptr", dut.ptr, 4'd0);
    @(negedge clk);
    rst = 0; clear_in();

    //        start stop wv  wb     hwe ha     hwd    gnt done st      ptr    ci     cv
    tbl[0]  = '{1, 0, 0, 8'h00, 0, 4'd0,  8'h00, 0, 0, S_PTR,  4'd5 - 4'd5, 4'd3, 8'h00};
    tbl[1]  = '{0, 0, 1, 8'h03, 0, 4'd0,  8'h00, 0, 0, S_WR,   4'd3,  4'd3,  8'h00};
    tbl[2]  = '{0, 0, 1, 8'h11, 0, 4'd0,  8'h00, 0, 0, S_WR,   4'd4,  4'd3,  8'h11};
    tbl[3]  = '{0, 0, 1, 8'h22, 0, 4'd0,  8'h00, 0, 0, S_WR,   4'd5,  4'd4,  8'h22};
    tbl[4]  = '{0, 1, 0, 8'h00, 0, 4'd0,  8'h00, 0, 1, S_IDLE, 4'd5,  4'd4,  8'h22};
    tbl[5]  = '{0, 0, 0, 8'h00, 0, 4'd0,  8'h00, 0, 0, S_IDLE, 4'd5,  4'd3,  8'h11};
    tbl[6]  = '{0, 1, 0, 8'h00, 0, 4'd0,  8'h00, 0, 0, S_IDLE, 4'd5,  4'd3,  8'h11};
    tbl[7]  = '{1, 0, 0, 8'h00, 0, 4'd0,  8'h00, 0, 0, S_PTR,  4'd5,  4'd14, 8'h00};
    tbl[8]  = '{0, 0, 1, 8'h0E, 0, 4'd0,  8'h00, 0, 0, S_WR,   4'd14, 4'd14, 8'h00};
    tbl[9]  = '{0, 0, 1, 8'hAA, 0, 4'd0,  8'h00, 0, 0, S_WR,   4'd15, 4'd14, 8'hAA};
    tbl[10] = '{0, 0, 1, 8'hBB, 0, 4'd0,  8'h00, 0, 0, S_WR,   4'd0,  4'd15, 8'hA5};
    tbl[11] = '{0, 0, 1, 8'hCC, 0, 4'd0,  8'h00, 0, 0, S_WR,   4'd1,  4'd0,  8'hCC};
    tbl[12] = '{0, 1, 0, 8'h00, 0, 4'd0,  8'h00, 0, 1, S_IDLE, 4'd1,  4'd0,  8'hCC};
    tbl[13] = '{0, 0, 0, 8'h00, 0, 4'd0,  8'h00, 0, 0, S_IDLE, 4'd1,  4'd14, 8'hAA};
    tbl[14] = '{0, 0, 0, 8'h00, 1, 4'd7,  8'h3C, 1, 0, S_IDLE, 4'd1,  4'd7,  8'h3C};
    tbl[15] = '{0, 0, 0, 8'h00, 1, 4'd15, 8'h00, 1, 0, S_IDLE, 4'd1,  4'd15, 8'hA5};
    tbl[16] = '{1, 0, 0, 8'h00, 0, 4'd0,  8'h00, 0, 0, S_PTR,  4'd1,  4'd2,  8'h00};
    tbl[17] = '{0, 0, 1, 8'hF2, 0, 4'd0,  8'h00, 0, 0, S_WR,   4'd2,  4'd2,  8'h00};
    tbl[18] = '{0, 0, 1, 8'h33, 1, 4'd2,  8'h77, 0, 0, S_WR,   4'd3,  4'd2,  8'h33};
    tbl[19] = '{0, 0, 0, 8'h00, 1, 4'd2,  8'h77, 1, 0, S_WR,   4'd3,  4'd2,  8'h77};
    tbl[20] = '{1, 0, 1, 8'h09, 0, 4'd0,  8'h00, 0, 0, S_PTR,  4'd3,  4'd3,  8'h11};
    tbl[21] = '{0, 0, 1, 8'h04, 0, 4'd0,  8'h00, 0, 0, S_WR,   4'd4,  4'd4,  8'h22};
    tbl[22] = '{0, 1, 1, 8'h99, 0, 4'd0,  8'h00, 0, 1, S_IDLE, 4'd5,  4'd4,  8'h99};
    tbl[23] = '{0, 0, 0, 8'h00, 0, 4'd0,  8'h00, 0, 0, S_IDLE, 4'd5,  4'd4,  8'h99};
    tbl[24] = '{1, 0, 0, 8'h00, 0, 4'd0,  8'h00, 0, 0, S_PTR,  4'd5,  4'd5,  8'h00};
    tbl[25] = '{0, 1, 0, 8'h00, 0, 4'd0,  8'h00, 0, 0, S_IDLE, 4'd5,  4'd5,  8'h00};
    tbl[26] = '{0, 0, 1, 8'h55, 0, 4'd0,  8'h00, 0, 0, S_IDLE, 4'd5,  4'd5,  8'h00};

    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      xfer_start = tbl[i].start; xfer_stop = tbl[i].stop;
      wr_valid = tbl[i].wv; wr_byte = tbl[i].wb;
      host_we = tbl[i].hwe; host_addr = tbl[i].ha; host_wdata = tbl[i].hwd;
      #1;
      chk($sformatf("v%0d_gnt", i), host_gnt, tbl[i].gnt);
      @(posedge clk); #1;
      clear_in();
      chk($sformatf("v%0d_done", i), wr_done, tbl[i].done);
      chk($sformatf("v%0d_state", i), 2'(dut.state), tbl[i].st);
      chk($sformatf("v%0d_ptr", i), dut.ptr, tbl[i].ptr);
      chk($sformatf("v%0d_reg%0d", i, tbl[i].ci), reg_at(tbl[i].ci), tbl[i].cv);
    end

    // Pointer set by a write, then repeated START and two streamed reads
    host_wr(4'd5, 8'h5A);
    host_wr(4'd6, 8'h6B);
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h05);
    drive(1, 0, 0, 8'h00);
    wait_rd_valid("rd0_valid");
    chk("rd0_byte", rd_byte, 8'h5A);
    rd_ready = 1;
    @(posedge clk); #1;
    rd_ready = 0;
    chk("rd0_consumed_valid", rd_valid, 1'b0);
    chk("rd0_done", wr_done, 1'b0);
    wait_rd_valid("rd1_valid");
    chk("rd1_byte", rd_byte, 8'h6B);
    rd_ready = 1;
    @(posedge clk); #1;
    rd_ready = 0;
    chk("rd_state", 2'(dut.state), S_RD);
    chk("rd_ptr", dut.ptr, 4'd7);
    chk("rd1_done", wr_done, 1'b0);
    drive(0, 0, 1, 8'h44);
    chk("rd_ignore_wr_reg7", reg_at(4'd7), 8'h3C);
    chk("rd_ignore_wr_ptr", dut.ptr, 4'd7);
    drive(0, 1, 0, 8'h00);
    chk("rd_stop_done", wr_done, 1'b0);
    chk("rd_stop_state", 2'(dut.state), S_IDLE);

    // Asynchronous reset in the middle of a write burst
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 1, 8'h02);
    drive(0, 0, 1, 8'hEE);
    chk("pre_rst_reg2", reg_at(4'd2), 8'hEE);
    @(negedge clk);
    wr_valid = 1; wr_byte = 8'h44; host_we = 1; host_addr = 4'd9; host_wdata = 8'h12;
    #2 rst = 1;
    #1;
    chk("arst_regs", regs_q, RST_IMG);
    chk("arst_state", 2'(dut.state), S_IDLE);
    chk("arst_ptr", dut.ptr, 4'd0);
    chk("arst_gnt", host_gnt, 1'b0);
    chk("arst_rd_valid", rd_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 0; clear_in();
    for (int c = 0; c < 4; c++) begin
      drive(0, c == 0, 1, 8'h07);
      chk($sformatf("post_rst%0d_done", c), wr_done, 1'b0);
      chk($sformatf("post_rst%0d_state", c), 2'(dut.state), S_IDLE);
    end
    chk("post_rst_regs", regs_q, RST_IMG);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
